// File: rtl/vadd_fxp_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vadd_fxp_wb_buffer
// Function : rounds averaging-add beats, then buffers result beats in a
//            first-word-fall-through FIFO ahead of the VRF write port.
// Revision : 1.0 - initial release
// ============================================================================
module vadd_fxp_wb_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH)+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_mask,
  input  logic                  in_fxp,
  input  logic [BE_WIDTH-1:0]   in_vd,
  input  logic [BE_WIDTH-1:0]   in_vd1,
  input  logic [1:0]            in_sew,
  input  logic [1:0]            in_vxrm,
  input  logic                  wb_ready,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [BE_WIDTH-1:0]   wb_be,
  output logic                  wb_mask,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  almost_full,
  output logic                  err_overflow
);
  localparam int                   c_PTR_W = $clog2(DEPTH);
  localparam int                   c_BI_W  = $clog2(BE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_FULL  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_AFULL = CNT_WIDTH'(DEPTH-1);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_vec;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BE_WIDTH-1:0]   r_be;
  logic                  r_mask;
  logic                  r_fxp;
  logic [BE_WIDTH-1:0]   r_vd;
  logic [BE_WIDTH-1:0]   r_vd1;
  logic [1:0]            r_sew;
  logic [1:0]            r_vxrm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_mask  <= 1'b0;
      r_fxp   <= 1'b0;
      r_vd    <= '0;
      r_vd1   <= '0;
      r_sew   <= '0;
      r_vxrm  <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_vec  <= in_vec;
        r_addr <= in_addr;
        r_be   <= in_be;
        r_mask <= in_mask;
        r_fxp  <= in_fxp;
        r_vd   <= in_vd;
        r_vd1  <= in_vd1;
        r_sew  <= in_sew;
        r_vxrm <= in_vxrm;
      end
    end
  end

  function automatic logic rnd_inc(input logic [1:0] vxrm, input logic d, input logic d1);
    case (vxrm)
      2'd0:    return d1;
      2'd1:    return d1 & d;
      2'd2:    return 1'b0;
      default: return ~d & d1;
    endcase
  endfunction

  logic                  w_do_round;
  logic [c_BI_W-1:0]     w_emask;
  logic [BE_WIDTH-1:0]   w_carry;
  logic [DATA_WIDTH-1:0] w_rnd;

  assign w_do_round = r_fxp & ~r_mask;
  assign w_carry[0] = 1'b0;

  always_comb begin
    w_emask = '0;
    case (r_sew)
      2'd0:    w_emask = c_BI_W'(0);
      2'd1:    w_emask = c_BI_W'(1);
      2'd2:    w_emask = c_BI_W'(3);
      default: w_emask = c_BI_W'(7);
    endcase
  end

  // Byte-lane ripple adder: a lane that starts an element injects its own
  // increment, every other lane takes the carry from the lane below.
  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
    localparam logic [c_BI_W-1:0] c_IDX = c_BI_W'(i);
    logic [c_BI_W-1:0] w_base;
    logic              w_cin;
    assign w_base = c_IDX & ~w_emask;
    assign w_cin  = (w_base == c_IDX) ?
                    (w_do_round & rnd_inc(r_vxrm, r_vd[w_base], r_vd1[w_base])) :
                    w_carry[i];
    if (i < BE_WIDTH-1) begin : g_mid
      assign {w_carry[i+1], w_rnd[8*i +: 8]} = {1'b0, r_vec[8*i +: 8]} + {8'b0, w_cin};
    end else begin : g_top
      assign w_rnd[8*i +: 8] = r_vec[8*i +: 8] + {7'b0, w_cin};
    end
  end

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [BE_WIDTH-1:0]   r_mem_be   [DEPTH];
  logic [DEPTH-1:0]      r_mem_mask;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_wb_valid;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [BE_WIDTH-1:0]   r_wb_be;
  logic                  r_wb_mask;
  logic                  r_almost_full;
  logic                  r_err_overflow;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_bypass;
  logic [c_PTR_W-1:0]    w_rd_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;

  assign w_pop     = r_wb_valid & wb_ready;
  assign w_push    = r_valid & ((r_count != c_FULL) | w_pop);
  assign w_drop    = r_valid & (r_count == c_FULL) & ~w_pop;
  assign w_rd_nxt  = r_rd_ptr + c_PTR_W'(w_pop);
  assign w_cnt_nxt = r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
  // Pushed beat becomes the head only when nothing older survives this edge.
  assign w_bypass  = w_push & (r_count == CNT_WIDTH'(w_pop));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_rnd;
      r_mem_addr[r_wr_ptr] <= r_addr;
      r_mem_be[r_wr_ptr]   <= r_be;
      r_mem_mask[r_wr_ptr] <= r_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_addr      <= '0;
      r_wb_be        <= '0;
      r_wb_mask      <= 1'b0;
      r_almost_full  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_wr_ptr      <= r_wr_ptr + c_PTR_W'(w_push);
      r_rd_ptr      <= w_rd_nxt;
      r_count       <= w_cnt_nxt;
      r_wb_valid    <= (w_cnt_nxt != '0);
      r_almost_full <= (w_cnt_nxt >= c_AFULL);
      if (w_drop) r_err_overflow <= 1'b1;
      if (w_cnt_nxt != '0) begin
        r_wb_data <= w_bypass ? w_rnd  : r_mem_data[w_rd_nxt];
        r_wb_addr <= w_bypass ? r_addr : r_mem_addr[w_rd_nxt];
        r_wb_be   <= w_bypass ? r_be   : r_mem_be[w_rd_nxt];
        r_wb_mask <= w_bypass ? r_mask : r_mem_mask[w_rd_nxt];
      end
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_addr      = r_wb_addr;
  assign wb_be        = r_wb_be;
  assign wb_mask      = r_wb_mask;
  assign fifo_count   = r_count;
  assign almost_full  = r_almost_full;
  assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vadd_fxp_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vadd_fxp_wb_buffer
// Function : scoreboard bench for vadd_fxp_wb_buffer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vadd_fxp_wb_buffer;
  localparam int DW = 64, BW = 8, AW = 32, DEPTH = 4, CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_vec = '0;
  logic [AW-1:0] in_addr = '0;
  logic [BW-1:0] in_be = '0;
  logic          in_mask = 1'b0;
  logic          in_fxp = 1'b0;
  logic [BW-1:0] in_vd = '0;
  logic [BW-1:0] in_vd1 = '0;
  logic [1:0]    in_sew = '0;
  logic [1:0]    in_vxrm = '0;
  logic          wb_ready = 1'b0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  logic [BW-1:0] wb_be;
  logic          wb_mask;
  logic [CW-1:0] fifo_count;
  logic          almost_full;
  logic          err_overflow;

  always #5 clk = ~clk;

  vadd_fxp_wb_buffer #(.DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_addr(in_addr),
    .in_be(in_be), .in_mask(in_mask), .in_fxp(in_fxp), .in_vd(in_vd), .in_vd1(in_vd1),
    .in_sew(in_sew), .in_vxrm(in_vxrm), .wb_ready(wb_ready), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_be(wb_be), .wb_mask(wb_mask),
    .fifo_count(fifo_count), .almost_full(almost_full), .err_overflow(err_overflow)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic          mask;
  } beat_t;

  beat_t         sb[$];
  beat_t         stg;
  bit            stg_v = 1'b0;
  bit            exp_ovf = 1'b0;
  bit            chk_en = 1'b0;
  logic [DW-1:0] last_data = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  // Element-wise rounding straight from the arithmetic definition.
  function automatic logic [DW-1:0] ref_round(input logic [DW-1:0] v, input logic [1:0] sew,
      input logic [1:0] vxrm, input logic [BW-1:0] vd, input logic [BW-1:0] vd1,
      input logic fxp, input logic mask);
    int nb, w, ne, lb;
    logic [DW-1:0] m, e, res;
    logic d, d1, r;
    if (!fxp || mask) return v;
    nb = 1 << sew;
    w = 8 * nb;
    ne = BW / nb;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int k = 0; k < ne; k++) begin
      lb = k * nb;
      d = vd[lb];
      d1 = vd1[lb];
      case (vxrm)
        2'd0: r = d1;
        2'd1: r = d1 & d;
        2'd2: r = 1'b0;
        default: r = ~d & d1;
      endcase
      e = ((v >> (k * w)) + {63'b0, r}) & m;
      res = res | (e << (k * w));
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference FIFO: one register stage, then a DEPTH-entry queue that drops when full.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      stg_v = 1'b0;
      exp_ovf = 1'b0;
      last_data = '0;
    end else begin
      if (stg_v) begin
        if (sb.size() < DEPTH) sb.push_back(stg);
        else exp_ovf = 1'b1;
      end
      stg_v = in_valid;
      if (in_valid)
        stg = '{ref_round(in_vec, in_sew, in_vxrm, in_vd, in_vd1, in_fxp, in_mask),
                in_addr, in_be, in_mask};
    end
  end

  // Monitor: compares status every cycle, pops and compares the head on a handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_valid", {63'b0, wb_valid}, {63'b0, sb.size() != 0});
      check("fifo_count", {61'b0, fifo_count}, 64'(sb.size()));
      check("almost_full", {63'b0, almost_full}, {63'b0, sb.size() >= DEPTH-1});
      check("err_overflow", {63'b0, err_overflow}, {63'b0, exp_ovf});
      if (sb.size() != 0) begin
        check("wb_data", wb_data, sb[0].data);
        check("wb_addr", {32'b0, wb_addr}, {32'b0, sb[0].addr});
        check("wb_be", {56'b0, wb_be}, {56'b0, sb[0].be});
        check("wb_mask", {63'b0, wb_mask}, {63'b0, sb[0].mask});
        if (wb_ready) begin
          last_data = sb[0].data;
          void'(sb.pop_front());
        end
      end else begin
        check("wb_data_hold", wb_data, last_data);
      end
    end
  end

  task automatic drive(input logic [DW-1:0] vec, input logic [1:0] sew, input logic [1:0] vxrm,
                       input logic fxp, input logic mask, input logic [BW-1:0] vd,
                       input logic [BW-1:0] vd1);
    in_valid = 1'b1;
    in_vec = vec;
    in_addr = $urandom;
    in_be = 8'($urandom);
    in_sew = sew;
    in_vxrm = vxrm;
    in_fxp = fxp;
    in_mask = mask;
    in_vd = vd;
    in_vd1 = vd1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic m;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    wb_ready = 1'b1;

    for (int x = 0; x < 4; x++) drive(64'h10, 2'd0, 2'(x), 1'b1, 1'b0, 8'h01, 8'h01);
    drive(64'h10, 2'd0, 2'd1, 1'b1, 1'b0, 8'h00, 8'h01);
    drive(64'h10, 2'd0, 2'd3, 1'b1, 1'b0, 8'h00, 8'h01);
    drive(64'hFF, 2'd1, 2'd0, 1'b1, 1'b0, 8'h00, 8'h01);
    drive(64'hFF, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00, 8'h01);
    drive(rnd64(), 2'd2, 2'd0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    drive(rnd64(), 2'd3, 2'd0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    idle(4);

    wb_ready = 1'b0;
    for (int x = 0; x < 5; x++) drive(rnd64(), 2'(x), 2'd0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    idle(4);
    wb_ready = 1'b1;
    idle(6);

    wb_ready = 1'b0;
    for (int x = 0; x < 4; x++) drive(rnd64(), 2'd2, 2'd1, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    idle(3);
    drive(rnd64(), 2'd3, 2'd0, 1'b1, 1'b0, 8'hFF, 8'hFF);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    idle(3);
    wb_ready = 1'b1;
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    for (int c = 0; c < 400; c++) begin
      wb_ready = ((c / 50) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        m = ($urandom_range(0, 3) == 0);
        drive(rnd64(), 2'($urandom), 2'($urandom), ~m & 1'($urandom), m,
              8'($urandom), 8'($urandom));
      end else begin
        idle(1);
      end
      if (c == 200) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    wb_ready = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vadd_fxp_wb_buffer.md
Name: vadd_fxp_wb_buffer

Overview:
- Sits directly downstream of the vector add/min/max/avg pipeline and consumes its result beats: out_vec, out_valid, out_addr, out_be, out_mask, out_vd, out_vd1 and out_fxp.
- For averaging-add beats (fxp flag set), it applies the vxrm rounding increment to each element using the per-element d and d-1 bits.
- It then queues every beat in a small first-word-fall-through FIFO with a valid/ready handshake toward the VRF write port.
- The upstream pipeline cannot stall. The FIFO therefore absorbs bursts, and the block exports occupancy to the issue logic for throttling.

Parameters:
- DATA_WIDTH, 64, result beat width in bits. Only 64 is supported.
- BE_WIDTH, DATA_WIDTH/8, byte-enable and vd/vd1 flag width.
- ADDR_WIDTH, 32, writeback address width.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
- CNT_WIDTH, $clog2(DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream beat valid (no backpressure)
- in_vec  in  DATA_WIDTH  upstream result data
- in_addr  in  ADDR_WIDTH  writeback address
- in_be  in  BE_WIDTH  byte enables
- in_mask  in  1  beat is a packed mask result
- in_fxp  in  1  beat is an averaging result that needs rounding
- in_vd  in  BE_WIDTH  bit d per element, flagged at the element's LSB byte index
- in_vd1  in  BE_WIDTH  bit d-1 per element, same indexing
- in_sew  in  2  element width: 0=8, 1=16, 2=32, 3=64. Held by the sequencer for the whole instruction.
- in_vxrm  in  2  rounding mode: 0=rnu, 1=rne, 2=rdn, 3=rod
- wb_ready  in  1  VRF write port accepts
- wb_valid  out  1  FIFO head valid
- wb_data  out  DATA_WIDTH  head data
- wb_addr  out  ADDR_WIDTH  head address
- wb_be  out  BE_WIDTH  head byte enables
- wb_mask  out  1  head mask flag
- fifo_count  out  CNT_WIDTH  current occupancy
- almost_full  out  1  fifo_count >= DEPTH-1
- err_overflow  out  1  sticky overflow flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0.
  - FIFO pointers and count go to 0, and the round-stage valid goes to 0.
  - A reset in the middle of operation discards all queued and in-flight beats.
- Stage R (one register stage):
  - Captures in_* every cycle.
  - r_valid <= in_valid. Data, address, be, mask and flags are captured only when in_valid=1.
- Rounding increment, per element e:
  - d = in_vd[LSB byte of e], d1 = in_vd1[LSB byte of e].
  - rnu: r = d1.
  - rne: r = d1 & d.
  - rdn: r = 0.
  - rod: r = ~d & d1.
- Rounded result per element: (element + r) mod 2^SEW.
  - Carry propagates across byte lanes inside an element and is killed at element boundaries chosen by in_sew.
- Which beats are rounded:
  - in_fxp=0 or in_mask=1: data passes through unchanged.
  - in_fxp=1 and in_mask=1 never occurs; mask takes priority.
- Enqueue:
  - r_valid=1 pushes the registered, rounded beat into the FIFO at the next edge.
- Timing:
  - in_valid at cycle N gives wb_valid at cycle N+2 when the FIFO was empty. This is first-word fall-through.
  - Full throughput is one beat per cycle.
- Handshake:
  - A pop occurs when wb_valid & wb_ready.
  - wb_* stay stable while wb_valid=1 and wb_ready=0.
- Simultaneous push and pop:
  - fifo_count is unchanged.
  - This is legal even at count=DEPTH, in which case the push is accepted.
  - With count=0, the pushed beat appears at the head on the following cycle; no bypass in the same cycle.
- Full boundary:
  - A push with count=DEPTH and no pop drops the beat.
  - err_overflow is set to 1 and held until rst.
- Empty boundary:
  - wb_valid=0 and wb_data holds its last value.
  - wb_ready while empty has no effect.
- Pointers wrap modulo DEPTH.
- fifo_count and almost_full are registered and reflect post-edge occupancy.

Test Plan:
- Rounding modes, sew=0, byte0=0x10, vd[0]=1, vd1[0]=1, fxp=1, wb_ready=1:
  - vxrm=0 -> byte0 0x11, two cycles after in_valid.
  - vxrm=1 -> 0x11.
  - vxrm=2 -> 0x10.
  - vxrm=3 -> 0x10.
  - With vd[0]=0, vd1[0]=1: rne -> 0x10, rod -> 0x11.
- Carry within element: sew=1, vec=0x0000_0000_0000_00FF, vd1[0]=1, rnu -> 0x0000_0000_0000_0100.
- Carry killed at element boundary: same beat with sew=0 -> byte0 0x00, byte1 0x00, i.e. the upper bytes are unchanged.
- Pass-through: fxp=0 or mask=1 with nonzero vd/vd1 -> wb_data equals in_vec exactly, and wb_mask follows in_mask.
- Backpressure and overflow, wb_ready=0, DEPTH=4:
  - Five consecutive beats A..E -> almost_full=1 after the third push, fifo_count=4, E dropped, err_overflow=1.
  - Then wb_ready=1 -> A, B, C, D pop in order and fifo_count returns to 0.
- Full plus simultaneous pop, then reset:
  - At count=4, push and pop in the same cycle -> count stays 4 and the new beat is retained.
  - Assert rst mid-drain -> wb_valid=0, fifo_count=0 and err_overflow=0 on the next cycle.
